// File: rtl/mem_responder.sv
// mem_responder
//   Multicycle memory responder. Holds a unified instruction/data word array,
//   accepts one read or write request at a time and answers after a fixed
//   number of wait states with a one-cycle mem_ready pulse.
//
//   Parameters
//     DEPTH_LOG2   log2 of the word count (default 8 -> 256 x 32-bit words)
//     WAIT_STATES  idle cycles between acceptance and response (0..15)
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous reset, active low
//     MemRead    in   read request (sampled in IDLE only)
//     MemWrite   in   write request (sampled in IDLE only)
//     addr[31:0] in   byte address, latched on acceptance
//     wdata[31:0]in   write data, latched on acceptance
//     rdata[31:0]out  read data, held until the next successful read
//     mem_ready  out  one-cycle completion pulse
//     busy       out  high from the cycle after acceptance through RESP
//     err        out  qualifies mem_ready: access rejected
//
//   Build option
//     MEM_ERR_CHECK_EN  when defined, rejects simultaneous read+write,
//                       misaligned addresses and addresses beyond the array.
//                       When undefined, err is 0, the address is taken modulo
//                       the depth and read+write performs the write only.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a request; requests accepted here only
//   S_WAIT | counting down wait states
//   S_RESP | access done, mem_ready (and err if rejected) high one cycle

module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    op_rd_q;
  logic                    op_wr_q;
  logic                    rej_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;

  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    rej_in;
  logic                    rd_in;
  logic                    wr_in;
  logic                    enter_resp;
  logic                    src_rd;
  logic                    src_wr;
  logic                    src_rej;
  logic [DEPTH_LOG2-1:0]   src_idx;
  logic [31:0]             src_wdata;
  logic                    do_write;
  logic                    do_read;

  assign req = MemRead | MemWrite;

`ifdef MEM_ERR_CHECK_EN
  assign rej_in = (MemRead & MemWrite)
                | (addr[1:0] != 2'b00)
                | (addr[31:DEPTH_LOG2+2] != '0);
  assign rd_in  = MemRead;
  assign wr_in  = MemWrite;
`else
  // Out-of-range and misaligned bits are simply dropped in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
  assign rej_in = 1'b0;
  // Read+write together degrades to a plain write.
  assign rd_in  = MemRead & ~MemWrite;
  assign wr_in  = MemWrite;
`endif

  // With zero wait states the array is accessed on the acceptance edge itself,
  // so the access must use the live inputs rather than the latched copies.
  assign enter_resp = ((state == S_WAIT) && (cnt == 4'd0))
                    || ((state == S_IDLE) && req && (WAIT_STATES == 0));

  always_comb begin
    src_rd    = op_rd_q;
    src_wr    = op_wr_q;
    src_rej   = rej_q;
    src_idx   = idx_q;
    src_wdata = wdata_q;
    if (state == S_IDLE) begin
      src_rd    = rd_in;
      src_wr    = wr_in;
      src_rej   = rej_in;
      src_idx   = addr[DEPTH_LOG2+1:2];
      src_wdata = wdata;
    end
  end

  assign do_write = enter_resp & src_wr & ~src_rej;
  assign do_read  = enter_resp & src_rd & ~src_wr & ~src_rej;

  // Array has no reset; a reset at the edge that would enter RESP blocks the write.
  always_ff @(posedge clk) begin
    if (rst && do_write) begin
      mem[src_idx] <= src_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0000_0000;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      rej_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0000_0000;
    end else begin
      mem_ready <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            op_rd_q <= rd_in;
            op_wr_q <= wr_in;
            rej_q   <= rej_in;
            idx_q   <= addr[DEPTH_LOG2+1:2];
            wdata_q <= wdata;
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        mem_ready <= 1'b1;
        err       <= src_rej;
        if (do_read) begin
          rdata <= mem[src_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] ad    [3];
  logic [31:0] wd    [3];
  logic [31:0] rdt   [3];
  logic        rdy   [3];
  logic        bsy   [3];
  logic        er    [3];

  int n_chk  = 0;
  int n_fail = 0;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst_n[0]), .MemRead(rd[0]), .MemWrite(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rdt[0]), .mem_ready(rdy[0]), .busy(bsy[0]), .err(er[0]));

  mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst_n[1]), .MemRead(rd[1]), .MemWrite(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rdt[1]), .mem_ready(rdy[1]), .busy(bsy[1]), .err(er[1]));

  mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst_n[2]), .MemRead(rd[2]), .MemWrite(wr[2]), .addr(ad[2]),
    .wdata(wd[2]), .rdata(rdt[2]), .mem_ready(rdy[2]), .busy(bsy[2]), .err(er[2]));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: request presented in cycle 0, response expected in
  // cycle ws+1, request dropped during RESP, IDLE checked the cycle after.
  task automatic access(input int k, input int ws, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input string tag);
    int early    = 0;
    int not_busy = 0;
    @(negedge clk);
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
    for (int c = 1; c <= ws; c++) begin
      @(posedge clk); #1;
      if (rdy[k] !== 1'b0 || er[k] !== 1'b0) early++;
      if (bsy[k] !== 1'b1) not_busy++;
    end
    @(posedge clk); #1;
    if (ws > 0) begin
      chk32({tag, " ready/err in wait"}, 32'(early), 32'd0);
      chk32({tag, " busy in wait"}, 32'(not_busy), 32'd0);
    end
    chk1({tag, " mem_ready"}, rdy[k], 1'b1);
    chk1({tag, " busy resp"}, bsy[k], 1'b1);
    chk1({tag, " err"}, er[k], exp_err);
    chk32({tag, " rdata"}, rdt[k], exp_rd);
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(posedge clk); #1;
    chk1({tag, " ready low after"}, rdy[k], 1'b0);
    chk1({tag, " busy low after"}, bsy[k], 1'b0);
  endtask

  initial begin
    int spurious;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0;
    end

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk32($sformatf("reset rdata%0d", k), rdt[k], 32'h0);
      chk1($sformatf("reset ready%0d", k), rdy[k], 1'b0);
      chk1($sformatf("reset busy%0d", k), bsy[k], 1'b0);
      chk1($sformatf("reset err%0d", k), er[k], 1'b0);
    end
    spurious = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdy[0] !== 1'b0 || bsy[0] !== 1'b0) spurious++;
    end
    chk32("idle no activity", 32'(spurious), 32'd0);

    // Write then read, WAIT_STATES=2
    access(0, 2, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0,        "ws2 wr10");
    access(0, 2, 1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 32'hCAFE_F00D, "ws2 rd10");
    access(0, 2, 1'b0, 1'b1, 32'h14, 32'h1111_1111, 1'b0, 32'hCAFE_F00D, "ws2 wr14");

`ifdef MEM_ERR_CHECK_EN
    access(0, 2, 1'b1, 1'b0, 32'h13,  32'h0,         1'b1, 32'hCAFE_F00D, "err misalign");
    access(0, 2, 1'b1, 1'b0, 32'h400, 32'h0,         1'b1, 32'hCAFE_F00D, "err range");
    access(0, 2, 1'b1, 1'b1, 32'h14,  32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D, "err rw both");
    access(0, 2, 1'b1, 1'b0, 32'h14,  32'h0,         1'b0, 32'h1111_1111, "rd14 unchanged");
`else
    access(0, 2, 1'b1, 1'b0, 32'h14,  32'h0,         1'b0, 32'h1111_1111, "rd14");
    access(0, 2, 1'b1, 1'b0, 32'h413, 32'h0,         1'b0, 32'hCAFE_F00D, "rd413 wraps");
    access(0, 2, 1'b1, 1'b1, 32'h14,  32'hDEAD_BEEF, 1'b0, 32'hCAFE_F00D, "rw both writes");
    access(0, 2, 1'b1, 1'b0, 32'h14,  32'h0,         1'b0, 32'hDEAD_BEEF, "rd14 written");
`endif

    // WAIT_STATES=0: single accesses, then back-to-back reads held continuously
    access(1, 0, 1'b0, 1'b1, 32'h0, 32'hA0A0_0001, 1'b0, 32'h0, "ws0 wr0");
    access(1, 0, 1'b0, 1'b1, 32'h4, 32'hB0B0_0002, 1'b0, 32'h0, "ws0 wr4");
    @(negedge clk);
    rd[1] = 1'b1; ad[1] = 32'h0;
    @(posedge clk); #1;
    chk1("b2b pulse1", rdy[1], 1'b1);
    chk32("b2b rdata1", rdt[1], 32'hA0A0_0001);
    ad[1] = 32'h4;
    @(posedge clk); #1;
    chk1("b2b gap", rdy[1], 1'b0);
    @(posedge clk); #1;
    chk1("b2b pulse2", rdy[1], 1'b1);
    chk32("b2b rdata2", rdt[1], 32'hB0B0_0002);
    rd[1] = 1'b0;
    @(posedge clk); #1;
    chk1("b2b end ready", rdy[1], 1'b0);
    chk1("b2b end busy", bsy[1], 1'b0);

    // Reset mid-operation, WAIT_STATES=3
    access(2, 3, 1'b0, 1'b1, 32'h20, 32'hAAAA_5555, 1'b0, 32'h0, "ws3 wr20");
    @(negedge clk);
    wr[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'h1234_5678;
    @(posedge clk); #1;
    chk1("midrst busy c1", bsy[2], 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0; wr[2] = 1'b0;
    @(posedge clk); #1;
    chk1("midrst busy", bsy[2], 1'b0);
    chk1("midrst ready", rdy[2], 1'b0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    spurious = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy[2] !== 1'b0) spurious++;
    end
    chk32("midrst no ready", 32'(spurious), 32'd0);

    // Reset landing exactly on the edge that would enter RESP
    @(negedge clk);
    wr[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'h8765_4321;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0; wr[2] = 1'b0;
    @(posedge clk); #1;
    chk1("resp-edge rst ready", rdy[2], 1'b0);
    chk1("resp-edge rst busy", bsy[2], 1'b0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    access(2, 3, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAAAA_5555, "ws3 rd20 old");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
